icache_dm: RTL and testbench

//  Direct-mapped L1 instruction cache between the pipelined CPU fetch stage and the shared memory bus.

---
 rtl/icache_dm_pkg.sv | 32 +++
 rtl/icache_dm_if.sv | 26 ++
 rtl/icache_dm_data_ram.sv | 22 ++
 rtl/icache_dm.sv | 173 +++++++++++++++++
 tb/tb_icache_dm.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_dm_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
// Field widths derive from LINE_WORDS / NUM_LINES; byte offset [1:0] is always dropped.
package icache_pkg;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_e;

    function automatic int offset_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int line_words, input int num_lines);
        return 30 - offset_w(line_words) - index_w(num_lines);
    endfunction

    // Fields come back right-justified; callers size-cast to the field width.
    function automatic logic [31:0] addr_offset(input logic [31:0] a, input int off_w);
        return (a >> 2) & ((32'd1 << off_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] a, input int off_w, input int idx_w);
        return (a >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int off_w, input int idx_w);
        return a >> (2 + off_w + idx_w);
    endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and memory-bus signals of icache_dm; the cache takes the slave view.
// Handshake: a request transfers on a clk edge where req_valid & req_ready; resp_valid is a
// one-cycle pulse with no backpressure; mem_ren stays high with a stable mem_addr until mem_done.
interface icache_dm_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        req_kill;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic        flush;
    logic [31:0] mem_addr;
    logic        mem_ren;
    logic [31:0] mem_rdata;
    logic        mem_done;

    modport master (
        output req_valid, req_addr, req_kill, flush, mem_rdata, mem_done,
        input  req_ready, resp_valid, resp_instr, mem_addr, mem_ren
    );

    modport slave (
        input  req_valid, req_addr, req_kill, flush, mem_rdata, mem_done,
        output req_ready, resp_valid, resp_instr, mem_addr, mem_ren
    );
endinterface

// File: rtl/icache_dm_data_ram.sv
// Single-port synchronous-read data store for the cache lines, read-first on write.
// Kept as one clocked block without reset so it maps onto block RAM.
module icache_data_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            rdata_o <= mem_q[addr_i];
        end
    end
endmodule

// File: rtl/icache_dm.sv
// Direct-mapped L1 instruction cache: 1-cycle hits, whole-line refill over a ren/done bus.
// Define ICACHE_STATS_EN to add the stat_hits / stat_misses counters.
module icache_dm
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic        clk,
    input  logic        rst,
    icache_dm_if.slave  bus,
    output state_e      dbg_state_o
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);
    localparam int OFFSET_W = offset_w(LINE_WORDS);
    localparam int INDEX_W  = index_w(NUM_LINES);
    localparam int TAG_W    = tag_w(LINE_WORDS, NUM_LINES);
    localparam int RAM_AW   = OFFSET_W + INDEX_W;
    localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(LINE_WORDS - 1);

    state_e                state_q, state_d;
    logic [OFFSET_W-1:0]   word_q, word_d, off_q;
    logic [INDEX_W-1:0]    idx_q;
    logic [TAG_W-1:0]      tag_q, tag_rd_q;
    logic [31:0]           cap_q, cap_d;
    logic                  kill_pend_q, kill_d, flush_pend_q, flush_d;
    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]      tag_mem [NUM_LINES];

    logic [OFFSET_W-1:0]   req_off;
    logic [INDEX_W-1:0]    req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  ready, resp_v, ram_we, tag_we, accept, hit;
    logic [RAM_AW-1:0]     ram_addr;
    logic [31:0]           ram_rdata;

    assign req_off = OFFSET_W'(addr_offset(bus.req_addr, OFFSET_W));
    assign req_idx = INDEX_W'(addr_index(bus.req_addr, OFFSET_W, INDEX_W));
    assign req_tag = TAG_W'(addr_tag(bus.req_addr, OFFSET_W, INDEX_W));

    assign hit    = valid_q[idx_q] && (tag_rd_q == tag_q);
    assign accept = bus.req_valid && ready;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cap_d   = cap_q;
        kill_d  = kill_pend_q;
        flush_d = flush_pend_q;
        valid_d = valid_q;
        ready   = 1'b0;
        resp_v  = 1'b0;
        ram_we  = 1'b0;
        tag_we  = 1'b0;
        case (state_q)
            IDLE: begin
                ready = rst && !bus.flush;
                if (bus.flush) valid_d = '0;
                else if (bus.req_valid && rst) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (bus.flush) begin
                    valid_d = '0;
                    state_d = IDLE;
                end else if (hit) begin
                    ready   = rst;
                    resp_v  = !bus.req_kill;
                    state_d = bus.req_valid ? LOOKUP : IDLE;
                end else begin
                    // A miss killed here still refills; the response is dropped later.
                    kill_d  = bus.req_kill;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (bus.req_kill) kill_d = 1'b1;
                if (bus.flush) flush_d = 1'b1;
                if (bus.mem_done) begin
                    ram_we = 1'b1;
                    word_d = word_q + 1'b1;
                    if (word_q == off_q) cap_d = bus.mem_rdata;
                    if (word_q == LAST_WORD) begin
                        tag_we = 1'b1;
                        if (!bus.flush) valid_d[idx_q] = 1'b1;
                        state_d = RESPOND;
                    end
                end
            end
            RESPOND: begin
                resp_v  = !kill_pend_q && !bus.req_kill;
                if (flush_pend_q || bus.flush) valid_d = '0;
                kill_d  = 1'b0;
                flush_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            word_q       <= '0;
            cap_q        <= '0;
            kill_pend_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            off_q        <= '0;
            idx_q        <= '0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            cap_q        <= cap_d;
            kill_pend_q  <= kill_d;
            flush_pend_q <= flush_d;
            valid_q      <= valid_d;
            if (accept) begin
                off_q <= req_off;
                idx_q <= req_idx;
                tag_q <= req_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) tag_mem[idx_q] <= tag_q;
        if (accept) tag_rd_q <= tag_mem[req_idx];
    end

    assign ram_addr = (state_q == REFILL) ? {idx_q, word_q} : {req_idx, req_off};

    icache_data_ram #(.DEPTH(NUM_LINES * LINE_WORDS), .AW(RAM_AW)) u_data_ram (
        .clk     (clk),
        .en_i    (accept || ram_we),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (bus.mem_rdata),
        .rdata_o (ram_rdata)
    );

    assign bus.req_ready  = ready;
    assign bus.resp_valid = resp_v;
    assign bus.resp_instr = (state_q == LOOKUP) ? ram_rdata : cap_q;
    assign bus.mem_ren    = (state_q == REFILL);
    assign bus.mem_addr   = (state_q == REFILL) ? {tag_q, idx_q, word_q, 2'b00} : 32'd0;
    assign dbg_state_o    = state_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hits_q, misses_q;
    logic        count_hit, count_miss;

    assign count_hit  = (state_q == LOOKUP) && !bus.flush && hit;
    assign count_miss = (state_q == LOOKUP) && !bus.flush && !hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            if (count_hit)  hits_q   <= hits_q + 32'd1;
            if (count_miss) misses_q <= misses_q + 32'd1;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: a bus model answers refills, a monitor checks responses
// against an expected queue filled by the stimulus driver.
module tb_icache_dm;
    import icache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    icache_dm_if bus();
    state_e      dbg_state;
`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    icache_dm #(.LINE_WORDS(4), .NUM_LINES(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          resp_cnt = 0;
    int          fetch_cnt = 0;
    int          wait_cycles = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_mem_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        if (rst && bus.resp_valid) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: got 0x%08h expected no response", bus.resp_instr);
            end else begin
                check("resp_instr", bus.resp_instr, exp_q.pop_front());
            end
        end
    end

    // ---------------- memory bus model ----------------
    initial begin
        int          wc;
        logic [31:0] hold_addr;
        wc = 0;
        hold_addr = '0;
        bus.mem_done  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_done = 1'b0;
            if (rst && bus.mem_ren) begin
                if (wc == 0) hold_addr = bus.mem_addr;
                else check("mem_addr_stable", bus.mem_addr, hold_addr);
                if (wc >= wait_cycles) begin
                    bus.mem_done  = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_addr);
                    fetch_cnt++;
                    if (exp_mem_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_fetch: got 0x%08h expected no bus read", bus.mem_addr);
                    end else begin
                        check("mem_addr", bus.mem_addr, exp_mem_q.pop_front());
                    end
                    wc = 0;
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_line(input logic [31:0] base);
        for (int w = 0; w < 4; w++) exp_mem_q.push_back(base + 32'(w * 4));
    endtask

    // Call between a posedge and the following negedge.
    task automatic issue(input logic [31:0] a);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
            if (n > 200) begin
                n_checks++;
                $display("FAIL accept_timeout: got no req_ready expected accept of 0x%08h", a);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_ren();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_ren) break;
            n++;
            if (n > 50) begin
                n_checks++;
                $display("FAIL ren_timeout: got mem_ren=0 expected 1");
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && exp_mem_q.size() == 0 && dbg_state == IDLE) break;
            n++;
            if (n > 300) begin
                n_checks++;
                $display("FAIL idle_timeout: got %0d resp / %0d reads pending expected 0/0",
                         exp_q.size(), exp_mem_q.size());
                exp_q.delete();
                exp_mem_q.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0, f0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_kill  = 1'b0;
        bus.flush     = 1'b0;

        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_mem_ren", 32'(bus.mem_ren), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss, then the rest of the line hits back-to-back
        push_line(32'h100);
        exp_q.push_back(32'hC0DE_0100);
        issue(32'h100);
        wait_idle();
        c0 = resp_cnt;
        f0 = fetch_cnt;
        exp_q.push_back(32'hC0DE_0104);
        exp_q.push_back(32'hC0DE_0108);
        exp_q.push_back(32'hC0DE_010C);
        issue(32'h104);
        issue(32'h108);
        issue(32'h10C);
        @(negedge clk);
        #1;
        check("b2b_resp_count", 32'(resp_cnt - c0), 32'd3);
        check("b2b_no_fetch", 32'(fetch_cnt - f0), 32'd0);
        wait_idle();

        // Conflict on index 0x10, then the evicted line misses again
        push_line(32'h500);
        exp_q.push_back(32'hC0DE_0508);
        issue(32'h508);
        wait_idle();
        push_line(32'h100);
        exp_q.push_back(32'hC0DE_0100);
        issue(32'h100);
        wait_idle();

        // Three wait states per word
        wait_cycles = 3;
        f0 = fetch_cnt;
        push_line(32'h600);
        exp_q.push_back(32'hC0DE_060C);
        issue(32'h60C);
        wait_idle();
        check("wait_fetch_count", 32'(fetch_cnt - f0), 32'd4);
        wait_cycles = 0;

        // Kill during refill: no response, but line becomes valid
        c0 = resp_cnt;
        push_line(32'h200);
        issue(32'h200);
        wait_ren();
        bus.req_kill = 1'b1;
        @(posedge clk);
        #1;
        bus.req_kill = 1'b0;
        wait_idle();
        check("kill_no_resp", 32'(resp_cnt - c0), 32'd0);
        f0 = fetch_cnt;
        exp_q.push_back(32'hC0DE_0200);
        issue(32'h200);
        @(negedge clk);
        check("kill_rehit_latency", 32'(bus.resp_valid), 32'd1);
        wait_idle();
        check("kill_rehit_no_fetch", 32'(fetch_cnt - f0), 32'd0);

        // Flush during refill: response delivered, line invalid afterwards
        push_line(32'h300);
        exp_q.push_back(32'hC0DE_0300);
        issue(32'h300);
        wait_ren();
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        wait_idle();
        f0 = fetch_cnt;
        push_line(32'h300);
        exp_q.push_back(32'hC0DE_0300);
        issue(32'h300);
        wait_idle();
        check("flush_refetch", 32'(fetch_cnt - f0), 32'd4);

        // Flush while idle blocks the request slot and invalidates
        bus.flush = 1'b1;
        #1;
        check("flush_ready_low", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        f0 = fetch_cnt;
        push_line(32'h300);
        exp_q.push_back(32'hC0DE_0304);
        issue(32'h304);
        wait_idle();
        check("idle_flush_refetch", 32'(fetch_cnt - f0), 32'd4);

        // Reset in the middle of a slow refill
        wait_cycles = 3;
        push_line(32'h100);
        exp_q.push_back(32'hC0DE_0100);
        issue(32'h100);
        wait_ren();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_mem_ren", 32'(bus.mem_ren), 32'd0);
        check("midrst_mem_addr", bus.mem_addr, 32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        exp_q.delete();
        exp_mem_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
`ifdef ICACHE_STATS_EN
        check("stat_hits_rst", stat_hits, 32'd0);
        check("stat_misses_rst", stat_misses, 32'd0);
`endif
        wait_cycles = 0;
        f0 = fetch_cnt;
        push_line(32'h100);
        exp_q.push_back(32'hC0DE_0100);
        issue(32'h100);
        wait_idle();
        check("postrst_refetch", 32'(fetch_cnt - f0), 32'd4);
`ifdef ICACHE_STATS_EN
        check("stat_hits_end", stat_hits, 32'd0);
        check("stat_misses_end", stat_misses, 32'd1);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
